// File: rtl/lector_destinos.sv
// Drain engine for destination FIFOs D0/D1: round-robin pops onto one
// valid/ready stream, with per-source counters and a sticky dest-mismatch flag.
// Ports: clk, reset_L (async, active-low), init (sync soft clear);
//   data_out0/1, empty_D0/1 from the FIFOs; out_ready from downstream;
//   pop_D0/1 to the FIFOs; data_out/valid_out/src_out stream;
//   cnt_D0/1 counters; error_out sticky flag; idle_out.
module lector_destinos #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [DATA_WIDTH-1:0] data_out0,
  input  logic [DATA_WIDTH-1:0] data_out1,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  input  logic                  out_ready,
  output logic                  pop_D0,
  output logic                  pop_D1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1,
  output logic                  error_out,
  output logic                  idle_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  src_q, src_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic                  err_q, err_d;

  logic                  ne0, ne1;
  logic                  pick;
  logic                  slot;
  logic                  can_pop;
  logic [DATA_WIDTH-1:0] word_w;

  assign ne0 = !empty_D0;
  assign ne1 = !empty_D1;

  // With both non-empty the source not served last wins;
  // otherwise the single non-empty one (ne1 is the index).
  assign pick = (ne0 && ne1) ? !rr_q : ne1;

  // A pop slot exists in IDLE, or in HOLD when the held
  // word leaves this cycle.
  assign slot = (state_q == S_IDLE) ||
                ((state_q == S_HOLD) && out_ready);

  assign can_pop = !init && (ne0 || ne1) && slot;

  assign pop_D0 = can_pop && !pick;
  assign pop_D1 = can_pop && pick;

  assign word_w = sel_q ? data_out1 : data_out0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          sel_d   = pick;
          rr_d    = pick;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        data_d  = word_w;
        src_d   = sel_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
        if (word_w[DEST_BIT] != sel_q) begin
          err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (sel_q) begin
            cnt1_d = cnt1_q + CNT_WIDTH'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_WIDTH'(1);
          end
          if (can_pop) begin
            sel_d   = pick;
            rr_d    = pick;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // Soft clear overrides everything; a word caught in
    // WAIT is dropped and never counted.
    if (init) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      data_d  = data_q;
      src_d   = src_q;
      cnt0_d  = '0;
      cnt1_d  = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b1;
      sel_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src_out   = src_q;
  assign cnt_D0    = cnt0_q;
  assign cnt_D1    = cnt1_q;
  assign error_out = err_q;
  assign idle_out  = (state_q == S_IDLE) && empty_D0 && empty_D1;

endmodule

// File: tb/tb_lector_destinos.sv
// Bench for lector_destinos: FIFO models, expected-order model,
// directed scenarios and randomized drains.
module tb_lector_destinos;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [5:0] data_out0;
  logic [5:0] data_out1;
  logic       empty_D0;
  logic       empty_D1;
  logic       out_ready;
  logic       pop_D0;
  logic       pop_D1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       src_out;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       error_out;
  logic       idle_out;

  lector_destinos #(
    .DATA_WIDTH(6),
    .DEST_BIT(4),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .init(init),
    .data_out0(data_out0),
    .data_out1(data_out1),
    .empty_D0(empty_D0),
    .empty_D1(empty_D1),
    .out_ready(out_ready),
    .pop_D0(pop_D0),
    .pop_D1(pop_D1),
    .data_out(data_out),
    .valid_out(valid_out),
    .src_out(src_out),
    .cnt_D0(cnt_D0),
    .cnt_D1(cnt_D1),
    .error_out(error_out),
    .idle_out(idle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;
  int last_acc;
  bit chk_gap;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] w0[$];
  logic [5:0] w1[$];
  logic [6:0] exp_q[$];
  logic       model_last;
  int         e_cnt0;
  int         e_cnt1;
  logic       e_err;

  task automatic step();
    logic p0, p1, bad, acc;
    logic [6:0] e;
    #1;
    p0 = pop_D0;
    p1 = pop_D1;
    bad = (p0 && p1) || (p0 && empty_D0) || (p1 && empty_D1) ||
          ((p0 || p1) && init);
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL pop_legal: pop0=%0b pop1=%0b e0=%0b e1=%0b init=%0b",
               p0, p1, empty_D0, empty_D1, init);
    end
    acc = valid_out && out_ready;
    if (acc) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got src=%0b data=%h, none expected",
                 src_out, data_out);
      end else begin
        e = exp_q.pop_front();
        if ({src_out, data_out} !== e) begin
          n_fail++;
          $display("FAIL word: got src=%0b data=%h, expected src=%0b data=%h",
                   src_out, data_out, e[6], e[5:0]);
        end
      end
      if (chk_gap && last_acc >= 0) begin
        n_chk++;
        if (cyc - last_acc != 2) begin
          n_fail++;
          $display("FAIL rate: gap %0d cycles, expected 2", cyc - last_acc);
        end
      end
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) data_out0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_out1 = q1.pop_front();
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    init = 1'b0;
    out_ready = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    data_out0 = '0;
    data_out1 = '0;
    empty_D0 = 1'b1;
    empty_D1 = 1'b1;
    model_last = 1'b1;
    e_cnt0 = 0;
    e_cnt1 = 0;
    e_err = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  // Fill both FIFOs under init so the drain starts from a known
  // snapshot, then derive the delivery order from the round-robin rule.
  task automatic load();
    int i0, i1;
    logic p;
    logic [5:0] d;
    init = 1'b1;
    foreach (w0[k]) q0.push_back(w0[k]);
    foreach (w1[k]) q1.push_back(w1[k]);
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
    step();
    step();
    init = 1'b0;
    e_cnt0 = 0;
    e_cnt1 = 0;
    e_err = 1'b0;
    i0 = 0;
    i1 = 0;
    while (i0 < w0.size() || i1 < w1.size()) begin
      if (i0 < w0.size() && i1 < w1.size()) p = !model_last;
      else p = (i1 < w1.size());
      if (p) begin
        d = w1[i1];
        i1++;
        e_cnt1++;
      end else begin
        d = w0[i0];
        i0++;
        e_cnt0++;
      end
      if (d[4] != p) e_err = 1'b1;
      exp_q.push_back({p, d});
      model_last = p;
    end
  endtask

  task automatic run_drain(input int budget, input bit rnd);
    chk_gap = !rnd;
    last_acc = -1;
    for (int k = 0; k < budget && exp_q.size() > 0; k++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    out_ready = 1'b1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    chk_gap = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    #1;
    n_chk++;
    if ({valid_out, data_out, src_out, cnt_D0, cnt_D1, error_out,
         pop_D0, pop_D1} !== '0 || idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: v=%0b d=%h s=%0b c0=%0d c1=%0d e=%0b idle=%0b",
               valid_out, data_out, src_out, cnt_D0, cnt_D1, error_out, idle_out);
    end
    do_reset();
  endtask

  task automatic test_d0_only();
    do_reset();
    w0 = {6'h1B, 6'h0D, 6'h03};
    w1 = {};
    load();
    run_drain(40, 1'b0);
    n_chk++;
    if (cnt_D0 !== 8'd3 || cnt_D1 !== 8'd0 || error_out !== 1'b1) begin
      n_fail++;
      $display("FAIL d0_only: c0=%0d c1=%0d err=%0b, expected 3 0 1",
               cnt_D0, cnt_D1, error_out);
    end
  endtask

  task automatic test_interleave();
    do_reset();
    w0 = {6'h0D, 6'h03};
    w1 = {6'h31, 6'h1A};
    load();
    run_drain(40, 1'b0);
    n_chk++;
    if (cnt_D0 !== 8'd2 || cnt_D1 !== 8'd2 || error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL interleave: c0=%0d c1=%0d err=%0b, expected 2 2 0",
               cnt_D0, cnt_D1, error_out);
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    w0 = {6'h05, 6'h02};
    w1 = {};
    load();
    out_ready = 1'b0;
    k = 0;
    while (!valid_out && k < 10) begin
      step();
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (valid_out !== 1'b1 || data_out !== 6'h05 || src_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: v=%0b d=%h s=%0b, expected 1 05 0",
                 valid_out, data_out, src_out);
      end
    end
    n_chk++;
    if (q0.size() != 1) begin
      n_fail++;
      $display("FAIL hold_no_pop: fifo0 has %0d, expected 1", q0.size());
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (pop_D0 !== 1'b1) begin
      n_fail++;
      $display("FAIL release_pop: pop_D0=%0b, expected 1", pop_D0);
    end
    run_drain(20, 1'b0);
  endtask

  task automatic test_idle();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (idle_out !== 1'b1 || pop_D0 !== 1'b0 || pop_D1 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: idle=%0b p0=%0b p1=%0b, expected 1 0 0",
                 idle_out, pop_D0, pop_D1);
      end
      step();
    end
    q1.push_back(6'h19);
    empty_D1 = 1'b0;
    exp_q.push_back({1'b1, 6'h19});
    model_last = 1'b1;
    #1;
    n_chk++;
    if (pop_D1 !== 1'b1 || pop_D0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pop: p0=%0b p1=%0b, expected 0 1", pop_D0, pop_D1);
    end
    step();
    n_chk++;
    if (valid_out !== 1'b0 || idle_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: v=%0b idle=%0b, expected 0 0", valid_out, idle_out);
    end
    out_ready = 1'b0;
    step();
    n_chk++;
    if (valid_out !== 1'b1 || data_out !== 6'h19 || idle_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: v=%0b d=%h idle=%0b, expected 1 19 0",
               valid_out, data_out, idle_out);
    end
    run_drain(10, 1'b0);
    n_chk++;
    if (cnt_D1 !== 8'd1 || idle_out !== 1'b1 || error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done: c1=%0d idle=%0b err=%0b, expected 1 1 0",
               cnt_D1, idle_out, error_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    w0 = {};
    w1 = {};
    for (int i = 0; i < 255; i++) w1.push_back(6'($urandom));
    load();
    run_drain(700, 1'b0);
    n_chk++;
    if (cnt_D1 !== 8'd255 || cnt_D0 !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_255: c1=%0d c0=%0d, expected 255 0", cnt_D1, cnt_D0);
    end
    q1.push_back(6'h12);
    empty_D1 = 1'b0;
    exp_q.push_back({1'b1, 6'h12});
    run_drain(10, 1'b0);
    n_chk++;
    if (cnt_D1 !== 8'd0 || cnt_D0 !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_0: c1=%0d c0=%0d, expected 0 0", cnt_D1, cnt_D0);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    w0 = {6'h02, 6'h03};
    w1 = {};
    load();
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 1 && k < 20) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    k = 0;
    while (!valid_out && k < 10) begin
      step();
      k++;
    end
    n_chk++;
    if (cnt_D0 !== 8'd1 || valid_out !== 1'b1 || data_out !== 6'h03) begin
      n_fail++;
      $display("FAIL pre_reset: c0=%0d v=%0b d=%h, expected 1 1 03",
               cnt_D0, valid_out, data_out);
    end
    #2;
    reset_L = 1'b0;
    #1;
    n_chk++;
    if ({valid_out, data_out, src_out, cnt_D0, cnt_D1, error_out} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%0b d=%h s=%0b c0=%0d c1=%0d e=%0b, expected 0",
               valid_out, data_out, src_out, cnt_D0, cnt_D1, error_out);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_init_wait();
    do_reset();
    w0 = {6'h01};
    w1 = {};
    load();
    run_drain(10, 1'b0);
    q1.push_back(6'h0A);
    empty_D1 = 1'b0;
    out_ready = 1'b1;
    step();
    model_last = 1'b1;
    n_chk++;
    if (q1.size() != 0 || cnt_D0 !== 8'd1) begin
      n_fail++;
      $display("FAIL init_setup: fifo1=%0d c0=%0d, expected 0 1",
               q1.size(), cnt_D0);
    end
    init = 1'b1;
    step();
    n_chk++;
    if (valid_out !== 1'b0 || cnt_D0 !== 8'd0 || cnt_D1 !== 8'd0 ||
        error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL init_wait: v=%0b c0=%0d c1=%0d e=%0b, expected 0 0 0 0",
               valid_out, cnt_D0, cnt_D1, error_out);
    end
    init = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_chk++;
    if (valid_out !== 1'b0 || cnt_D1 !== 8'd0 || idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL init_after: v=%0b c1=%0d idle=%0b, expected 0 0 1",
               valid_out, cnt_D1, idle_out);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_reset();
      w0 = {};
      w1 = {};
      for (int i = 0; i < int'($urandom_range(0, 8)); i++)
        w0.push_back(6'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 8)); i++)
        w1.push_back(6'($urandom));
      load();
      run_drain(400, it[0]);
      n_chk++;
      if (int'(cnt_D0) != e_cnt0 || int'(cnt_D1) != e_cnt1 ||
          error_out !== e_err) begin
        n_fail++;
        $display("FAIL random_%0d: c0=%0d c1=%0d e=%0b, expected %0d %0d %0b",
                 it, cnt_D0, cnt_D1, error_out, e_cnt0, e_cnt1, e_err);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    last_acc = -1;
    chk_gap = 1'b0;
    reset_L = 1'b0;
    init = 1'b0;
    out_ready = 1'b0;
    data_out0 = '0;
    data_out1 = '0;
    empty_D0 = 1'b1;
    empty_D1 = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    test_reset();
    test_d0_only();
    test_interleave();
    test_backpressure();
    test_idle();
    test_wrap();
    test_reset_mid();
    test_init_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
